// File: rtl/cdc_fifo_write_control.sv
// Write-side pointer and flag logic for an asynchronous FIFO.
// Synchronizes the Gray read pointer, then derives full/almost_full/free_count.
module cdc_fifo_write_control #(
  parameter int ADDRESS_WIDTH         = 4,
  parameter int ALMOST_FULL_THRESHOLD = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     increment,
  input  logic                     clear_overflow,
  input  logic [ADDRESS_WIDTH-1:0] read_address_gray,
  output logic                     write_enable,
  output logic [ADDRESS_WIDTH-1:0] write_address,
  output logic [ADDRESS_WIDTH-1:0] write_address_gray,
  output logic                     full,
  output logic                     almost_full,
  output logic                     overflow,
  output logic [ADDRESS_WIDTH-1:0] free_count
);

  localparam logic [31:0] AF_THRESHOLD = ALMOST_FULL_THRESHOLD;

  logic [ADDRESS_WIDTH-1:0] r_sync1;
  logic [ADDRESS_WIDTH-1:0] r_sync2;
  logic [ADDRESS_WIDTH-1:0] r_write_address;
  logic [ADDRESS_WIDTH-1:0] r_write_address_gray;
  logic                     r_overflow;

  logic [ADDRESS_WIDTH-1:0] w_read_address_sync;
  logic [ADDRESS_WIDTH-1:0] w_write_address_next;
  logic [ADDRESS_WIDTH-1:0] w_free_count;
  logic                     w_full;
  logic                     w_write_enable;

  // Gray to binary: each bit is the XOR of itself and every more-significant bit.
  genvar gi;
  generate
    for (gi = 0; gi < ADDRESS_WIDTH; gi++) begin : g_gray2bin
      assign w_read_address_sync[gi] = ^r_sync2[ADDRESS_WIDTH-1:gi];
    end
  endgenerate

  assign w_write_address_next = r_write_address + 1'b1;
  assign w_free_count         = w_read_address_sync - r_write_address - 1'b1;
  assign w_full               = (w_write_address_next == w_read_address_sync);
  assign w_write_enable       = increment & ~w_full & ~reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1              <= '0;
      r_sync2              <= '0;
      r_write_address      <= '0;
      r_write_address_gray <= '0;
      r_overflow           <= 1'b0;
    end else begin
      r_sync1 <= read_address_gray;
      r_sync2 <= r_sync1;
      if (w_write_enable) begin
        r_write_address      <= w_write_address_next;
        r_write_address_gray <= (w_write_address_next >> 1) ^ w_write_address_next;
      end
      // A new overflow event takes priority over a clear in the same cycle.
      if (increment && w_full)
        r_overflow <= 1'b1;
      else if (clear_overflow)
        r_overflow <= 1'b0;
    end
  end

  assign write_enable       = w_write_enable;
  assign write_address      = r_write_address;
  assign write_address_gray = r_write_address_gray;
  assign full               = w_full;
  assign almost_full        = ({{(32-ADDRESS_WIDTH){1'b0}}, w_free_count} <= AF_THRESHOLD);
  assign overflow           = r_overflow;
  assign free_count         = w_free_count;

endmodule

// File: tb/tb_cdc_fifo_write_control.sv
// Bench for cdc_fifo_write_control: directed fill/drain/overflow/reset steps
// followed by randomized traffic, checked against an occupancy-based model.
module tb_cdc_fifo_write_control;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int CAP   = DEPTH - 1;
  localparam int AFT   = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          increment;
  logic          clear_overflow;
  logic [AW-1:0] read_address_gray;
  logic          write_enable;
  logic [AW-1:0] write_address;
  logic [AW-1:0] write_address_gray;
  logic          full;
  logic          almost_full;
  logic          overflow;
  logic [AW-1:0] free_count;

  cdc_fifo_write_control #(.ADDRESS_WIDTH(AW), .ALMOST_FULL_THRESHOLD(AFT)) dut (
    .clock              (clock),
    .reset              (reset),
    .increment          (increment),
    .clear_overflow     (clear_overflow),
    .read_address_gray  (read_address_gray),
    .write_enable       (write_enable),
    .write_address      (write_address),
    .write_address_gray (write_address_gray),
    .full               (full),
    .almost_full        (almost_full),
    .overflow           (overflow),
    .free_count         (free_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Model: total accepted writes, read pointers presented at the input
  // (history), sticky overflow flag.
  int m_writes;
  int m_ovf;
  int rd_hist[$];
  int rd_ptr;
  int accepted;
  logic [AW-1:0] prev_gray;

  function automatic logic [AW-1:0] to_gray(input int n);
    logic [AW-1:0] b;
    b = n[AW-1:0];
    return (b >> 1) ^ b;
  endfunction

  // The write side sees the read pointer presented two edges earlier.
  function automatic int m_seen_rd();
    return rd_hist[rd_hist.size()-2];
  endfunction

  function automatic int m_occupancy();
    return (m_writes - m_seen_rd()) & (DEPTH - 1);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic rst, input logic inc, input logic clr);
    bit m_full_now;
    bit exp_we;
    @(negedge clock);
    reset             = rst;
    increment         = inc;
    clear_overflow    = clr;
    read_address_gray = to_gray(rd_ptr);
    #1;
    m_full_now = (m_occupancy() == CAP);
    exp_we     = !rst && inc && !m_full_now;
    chk("write_enable", int'(write_enable), int'(exp_we));
    @(posedge clock);
    if (rst) begin
      m_writes = 0;
      m_ovf    = 0;
      rd_hist  = '{0, 0};
    end else begin
      if (exp_we) begin
        m_writes++;
        accepted++;
      end
      if (inc && m_full_now) m_ovf = 1;
      else if (clr)          m_ovf = 0;
      rd_hist.push_back(rd_ptr);
      if (rd_hist.size() > 4) void'(rd_hist.pop_front());
    end
    #1;
    chk("write_address", int'(write_address), m_writes % DEPTH);
    chk("write_address_gray", int'(write_address_gray), int'(to_gray(m_writes)));
    chk("free_count", int'(free_count), CAP - m_occupancy());
    chk("full", int'(full), int'(m_occupancy() == CAP));
    chk("almost_full", int'(almost_full), int'((CAP - m_occupancy()) <= AFT));
    chk("overflow", int'(overflow), m_ovf);
    if (!rst && write_address_gray != prev_gray)
      chk("gray_one_bit", $countones(write_address_gray ^ prev_gray), 1);
    prev_gray = write_address_gray;
  endtask

  initial begin
    m_writes = 0; m_ovf = 0; rd_hist = '{0, 0}; rd_ptr = 0; accepted = 0;
    prev_gray = '0;
    reset = 1'b1; increment = 1'b0; clear_overflow = 1'b0; read_address_gray = '0;

    // Reset state.
    cyc(1, 1, 0);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("reset_free_count", int'(free_count), 15);
    chk("reset_full", int'(full), 0);

    // Fill with the read pointer held at 0: 15 writes then an overflow request.
    for (int i = 0; i < 16; i++) cyc(0, 1, 0);
    chk("fill_write_address", int'(write_address), 15);
    chk("fill_gray", int'(write_address_gray), 4'b1000);
    chk("fill_full", int'(full), 1);
    chk("fill_overflow", int'(overflow), 1);

    // Drain release: read pointer advances to 1, seen after two edges.
    rd_ptr = 1;
    cyc(0, 0, 0);
    chk("drain_full_edge1", int'(full), 1);
    cyc(0, 0, 0);
    chk("drain_full_edge2", int'(full), 0);
    chk("drain_free_count", int'(free_count), 1);
    cyc(0, 1, 0);
    chk("drain_wrap_address", int'(write_address), 0);

    // Overflow clear, then clear while a new overflow event occurs.
    cyc(0, 0, 1);
    chk("ovf_cleared", int'(overflow), 0);
    cyc(0, 1, 0);
    cyc(0, 1, 1);
    chk("ovf_set_wins", int'(overflow), 1);
    cyc(0, 0, 1);

    // Mid-run reset after 7 writes.
    rd_ptr = 0;
    cyc(1, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 1, 0);
    chk("midrun_address_7", int'(write_address), 7);
    cyc(1, 1, 0);
    chk("midrun_reset_address", int'(write_address), 0);
    cyc(0, 1, 0);
    chk("midrun_resume_address", int'(write_address), 1);

    // Randomized traffic with a trailing read pointer.
    accepted = 0;
    for (int i = 0; i < 500; i++) begin
      logic rst, inc, clr;
      rst = ($urandom_range(0, 149) == 0);
      inc = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 7) == 0);
      if (rst) rd_ptr = 0;
      else if ((rd_ptr % DEPTH) != (m_writes % DEPTH) && $urandom_range(0, 1) == 1)
        rd_ptr = (rd_ptr + 1) % DEPTH;
      cyc(rst, inc, clr);
    end
    chk("random_enough_writes", int'(accepted >= 32), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
